// File: rtl/mms_pkg.sv
// Shared MMS types: flush modes, TLB tag layout and the PTE global-bit position.
// The tag struct widths set the default VPN/ASID widths used by the TLB array.
package mms_pkg;

    localparam int unsigned TLB_VPN_W  = 27;
    localparam int unsigned TLB_ASID_W = 16;
    localparam int unsigned PTE_G_BIT  = 5;

    typedef enum logic [1:0] {
        FLUSH_ALL      = 2'd0,
        FLUSH_ASID     = 2'd1,
        FLUSH_VPN      = 2'd2,
        FLUSH_VPN_ASID = 2'd3
    } flush_mode_e;

    typedef struct packed {
        logic [TLB_VPN_W-1:0]  vpn;
        logic [TLB_ASID_W-1:0] asid;
        logic                  g;
    } tlb_tag_t;

    // Index of the lowest set bit; 0 when the vector is empty.
    function automatic logic [5:0] lowest_idx(input logic [63:0] vec);
        logic [5:0] idx;
        idx = '0;
        for (int i = 63; i >= 0; i--) begin
            if (vec[i]) begin
                idx = i[5:0];
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/tlb_assoc_entry.sv
// One TLB entry: tag, PTE and valid bit, with a lookup comparator and a gated PTE output.
// Only the valid bit is reset; tag and PTE contents are don't-care while invalid.
module tlb_assoc_entry
    import mms_pkg::*;
#(
    parameter int unsigned VPN_W  = TLB_VPN_W,
    parameter int unsigned ASID_W = TLB_ASID_W,
    parameter int unsigned PTE_W  = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [VPN_W-1:0]  wr_vpn_i,
    input  logic [ASID_W-1:0] wr_asid_i,
    input  logic [PTE_W-1:0]  wr_pte_i,
    input  logic              clr_i,
    input  logic [VPN_W-1:0]  lkp_vpn_i,
    input  logic [ASID_W-1:0] lkp_asid_i,
    output logic              valid_o,
    output logic [VPN_W-1:0]  vpn_o,
    output logic [ASID_W-1:0] asid_o,
    output logic              g_o,
    output logic              match_o,
    output logic [PTE_W-1:0]  pte_o
);

    logic             valid_d, valid_q;
    tlb_tag_t         tag_d, tag_q;
    logic [PTE_W-1:0] pte_d, pte_q;

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        pte_d   = pte_q;
        if (clr_i) begin
            valid_d = 1'b0;
        end else if (we_i) begin
            valid_d = 1'b1;
        end
        if (we_i) begin
            tag_d.vpn  = wr_vpn_i;
            tag_d.asid = wr_asid_i;
            tag_d.g    = wr_pte_i[PTE_G_BIT];
            pte_d      = wr_pte_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk_i) begin
        tag_q <= tag_d;
        pte_q <= pte_d;
    end

    always_comb begin
        valid_o = valid_q;
        vpn_o   = tag_q.vpn;
        asid_o  = tag_q.asid;
        g_o     = tag_q.g;
        match_o = valid_q && (tag_q.vpn == lkp_vpn_i) && (tag_q.g || (tag_q.asid == lkp_asid_i));
        pte_o   = match_o ? pte_q : '0;
    end

endmodule

// File: rtl/tlb_assoc_array.sv
// Fully-associative TLB store: parallel CAM lookup with a registered response, refill with
// victim selection and sfence.vma flushes. Flush always takes precedence over refill.
module tlb_assoc_array
    import mms_pkg::*;
#(
    parameter int unsigned ENTRY_NUM = 16,
    parameter int unsigned VPN_W     = TLB_VPN_W,
    parameter int unsigned ASID_W    = TLB_ASID_W,
    parameter int unsigned PTE_W     = 64
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         lkp_valid_i,
    input  logic [VPN_W-1:0]             lkp_vpn_i,
    input  logic [ASID_W-1:0]            lkp_asid_i,
    output logic                         rsp_valid_o,
    output logic                         rsp_hit_o,
    output logic [PTE_W-1:0]             rsp_pte_o,
    output logic [$clog2(ENTRY_NUM)-1:0] rsp_idx_o,
    output logic                         rsp_multihit_o,
    input  logic                         refill_valid_i,
    input  logic [VPN_W-1:0]             refill_vpn_i,
    input  logic [ASID_W-1:0]            refill_asid_i,
    input  logic [PTE_W-1:0]             refill_pte_i,
    input  logic                         flush_valid_i,
    input  logic [1:0]                   flush_mode_i,
    input  logic [VPN_W-1:0]             flush_vpn_i,
    input  logic [ASID_W-1:0]            flush_asid_i
);

    localparam int unsigned IDX_W = $clog2(ENTRY_NUM);

    logic [ENTRY_NUM-1:0] ent_valid, ent_g, ent_match, ent_we, ent_clr, refill_match;
    logic [VPN_W-1:0]     ent_vpn  [ENTRY_NUM];
    logic [ASID_W-1:0]    ent_asid [ENTRY_NUM];
    logic [PTE_W-1:0]     ent_pte  [ENTRY_NUM];

    logic [IDX_W-1:0] victim_d, victim_q, wr_idx;
    logic             refill_go;
    logic [5:0]       refill_match_idx, invalid_idx, lkp_idx;

    logic             rsp_valid_d, rsp_valid_q;
    logic             rsp_hit_d, rsp_hit_q;
    logic [PTE_W-1:0] rsp_pte_d, rsp_pte_q;
    logic [IDX_W-1:0] rsp_idx_d, rsp_idx_q;
    logic             rsp_multihit_d, rsp_multihit_q;
    logic [PTE_W-1:0] pte_or;

    for (genvar e = 0; e < ENTRY_NUM; e++) begin : g_entry
        tlb_assoc_entry #(
            .VPN_W  (VPN_W),
            .ASID_W (ASID_W),
            .PTE_W  (PTE_W)
        ) u_entry (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .we_i       (ent_we[e]),
            .wr_vpn_i   (refill_vpn_i),
            .wr_asid_i  (refill_asid_i),
            .wr_pte_i   (refill_pte_i),
            .clr_i      (ent_clr[e]),
            .lkp_vpn_i  (lkp_vpn_i),
            .lkp_asid_i (lkp_asid_i),
            .valid_o    (ent_valid[e]),
            .vpn_o      (ent_vpn[e]),
            .asid_o     (ent_asid[e]),
            .g_o        (ent_g[e]),
            .match_o    (ent_match[e]),
            .pte_o      (ent_pte[e])
        );

        always_comb begin
            refill_match[e] = ent_valid[e] && (ent_vpn[e] == refill_vpn_i) &&
                              (ent_g[e] || (ent_asid[e] == refill_asid_i));
            ent_clr[e] = 1'b0;
            if (flush_valid_i) begin
                case (flush_mode_e'(flush_mode_i))
                    FLUSH_ALL:      ent_clr[e] = 1'b1;
                    FLUSH_ASID:     ent_clr[e] = (ent_asid[e] == flush_asid_i) && !ent_g[e];
                    FLUSH_VPN:      ent_clr[e] = (ent_vpn[e] == flush_vpn_i);
                    FLUSH_VPN_ASID: ent_clr[e] = (ent_vpn[e] == flush_vpn_i) &&
                                                 (ent_asid[e] == flush_asid_i) && !ent_g[e];
                    default:        ent_clr[e] = 1'b0;
                endcase
            end
            ent_we[e] = refill_go && (wr_idx == e[IDX_W-1:0]);
        end
    end

    // Victim selection: existing tag first, then lowest free slot, then round-robin.
    always_comb begin
        refill_go        = refill_valid_i && !flush_valid_i;
        refill_match_idx = lowest_idx(64'(refill_match));
        invalid_idx      = lowest_idx(64'(~ent_valid));
        victim_d         = victim_q;
        if (|refill_match) begin
            wr_idx = refill_match_idx[IDX_W-1:0];
        end else if (!(&ent_valid)) begin
            wr_idx = invalid_idx[IDX_W-1:0];
        end else begin
            wr_idx = victim_q;
            if (refill_go) begin
                victim_d = victim_q + 1'b1;
            end
        end
    end

    always_comb begin
        pte_or = '0;
        for (int e = 0; e < ENTRY_NUM; e++) begin
            pte_or = pte_or | ent_pte[e];
        end
        lkp_idx        = lowest_idx(64'(ent_match));
        rsp_valid_d    = lkp_valid_i;
        rsp_hit_d      = 1'b0;
        rsp_pte_d      = '0;
        rsp_idx_d      = '0;
        rsp_multihit_d = 1'b0;
        if (lkp_valid_i && !flush_valid_i) begin
            rsp_hit_d      = |ent_match;
            rsp_pte_d      = pte_or;
            rsp_idx_d      = lkp_idx[IDX_W-1:0];
            rsp_multihit_d = (ent_match & (ent_match - 1'b1)) != '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            victim_q       <= '0;
            rsp_valid_q    <= 1'b0;
            rsp_hit_q      <= 1'b0;
            rsp_pte_q      <= '0;
            rsp_idx_q      <= '0;
            rsp_multihit_q <= 1'b0;
        end else begin
            victim_q       <= victim_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_hit_q      <= rsp_hit_d;
            rsp_pte_q      <= rsp_pte_d;
            rsp_idx_q      <= rsp_idx_d;
            rsp_multihit_q <= rsp_multihit_d;
        end
    end

    assign rsp_valid_o    = rsp_valid_q;
    assign rsp_hit_o      = rsp_hit_q;
    assign rsp_pte_o      = rsp_pte_q;
    assign rsp_idx_o      = rsp_idx_q;
    assign rsp_multihit_o = rsp_multihit_q;

endmodule

// File: tb/tb_tlb_assoc_array.sv
// Directed bench for tlb_assoc_array: lookup, refill/victim, flush modes, multihit, reset.
module tb_tlb_assoc_array;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        lkp_valid_i = 1'b0;
    logic [26:0] lkp_vpn_i = '0;
    logic [15:0] lkp_asid_i = '0;
    logic        rsp_valid_o, rsp_hit_o, rsp_multihit_o;
    logic [63:0] rsp_pte_o;
    logic [3:0]  rsp_idx_o;
    logic        refill_valid_i = 1'b0;
    logic [26:0] refill_vpn_i = '0;
    logic [15:0] refill_asid_i = '0;
    logic [63:0] refill_pte_i = '0;
    logic        flush_valid_i = 1'b0;
    logic [1:0]  flush_mode_i = '0;
    logic [26:0] flush_vpn_i = '0;
    logic [15:0] flush_asid_i = '0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_i = ~clk_i;

    tlb_assoc_array #(
        .ENTRY_NUM (16),
        .VPN_W     (27),
        .ASID_W    (16),
        .PTE_W     (64)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .lkp_valid_i    (lkp_valid_i),
        .lkp_vpn_i      (lkp_vpn_i),
        .lkp_asid_i     (lkp_asid_i),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_hit_o      (rsp_hit_o),
        .rsp_pte_o      (rsp_pte_o),
        .rsp_idx_o      (rsp_idx_o),
        .rsp_multihit_o (rsp_multihit_o),
        .refill_valid_i (refill_valid_i),
        .refill_vpn_i   (refill_vpn_i),
        .refill_asid_i  (refill_asid_i),
        .refill_pte_i   (refill_pte_i),
        .flush_valid_i  (flush_valid_i),
        .flush_mode_i   (flush_mode_i),
        .flush_vpn_i    (flush_vpn_i),
        .flush_asid_i   (flush_asid_i)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock, sample point is 1ns after the edge, then idle all requests.
    task automatic tick();
        @(posedge clk_i);
        #1;
        lkp_valid_i    = 1'b0;
        refill_valid_i = 1'b0;
        flush_valid_i  = 1'b0;
    endtask

    task automatic refill(input logic [26:0] vpn, input logic [15:0] asid, input logic [63:0] pte);
        refill_valid_i = 1'b1;
        refill_vpn_i   = vpn;
        refill_asid_i  = asid;
        refill_pte_i   = pte;
        tick();
    endtask

    task automatic flush(input logic [1:0] mode, input logic [26:0] vpn, input logic [15:0] asid);
        flush_valid_i = 1'b1;
        flush_mode_i  = mode;
        flush_vpn_i   = vpn;
        flush_asid_i  = asid;
        tick();
    endtask

    task automatic lookup(input logic [26:0] vpn, input logic [15:0] asid);
        lkp_valid_i = 1'b1;
        lkp_vpn_i   = vpn;
        lkp_asid_i  = asid;
        tick();
    endtask

    // Lookup and compare hit/pte/idx; a miss expects zero pte and index.
    task automatic expect_lookup(input string tag, input logic [26:0] vpn, input logic [15:0] asid,
                                 input logic hit, input logic [63:0] pte, input logic [3:0] idx);
        lookup(vpn, asid);
        check({tag, ".valid"}, 64'(rsp_valid_o), 64'd1);
        check({tag, ".hit"}, 64'(rsp_hit_o), 64'(hit));
        check({tag, ".pte"}, rsp_pte_o, pte);
        check({tag, ".idx"}, 64'(rsp_idx_o), 64'(idx));
    endtask

    initial begin
        repeat (2) @(posedge clk_i);
        #1;
        check("rst.valid", 64'(rsp_valid_o), 64'd0);
        check("rst.hit", 64'(rsp_hit_o), 64'd0);
        check("rst.pte", rsp_pte_o, 64'd0);
        check("rst.multihit", 64'(rsp_multihit_o), 64'd0);
        rst_i = 1'b0;

        // 1-2: cold miss, refill, hit, ASID mismatch
        expect_lookup("t1", 27'h123, 16'd1, 1'b0, 64'h0, 4'd0);
        tick();
        check("t1.idle_valid", 64'(rsp_valid_o), 64'd0);
        refill(27'h123, 16'd1, 64'hCF);
        expect_lookup("t2.hit", 27'h123, 16'd1, 1'b1, 64'hCF, 4'd0);
        expect_lookup("t2.asid", 27'h123, 16'd2, 1'b0, 64'h0, 4'd0);

        // 3: fill, then round-robin replacement from victim 0
        for (int i = 1; i < 16; i++) begin
            refill(27'h200 + 27'(i), 16'd1, 64'h100 + 64'(i));
        end
        expect_lookup("t3.e15", 27'h20F, 16'd1, 1'b1, 64'h10F, 4'd15);
        for (int k = 0; k < 4; k++) begin
            refill(27'h300 + 27'(k), 16'd1, 64'h80 + 64'(k));
        end
        for (int k = 0; k < 4; k++) begin
            expect_lookup("t3.new", 27'h300 + 27'(k), 16'd1, 1'b1, 64'h80 + 64'(k), 4'(k));
        end
        expect_lookup("t3.old0", 27'h123, 16'd1, 1'b0, 64'h0, 4'd0);
        expect_lookup("t3.old3", 27'h203, 16'd1, 1'b0, 64'h0, 4'd0);
        expect_lookup("t3.e4", 27'h204, 16'd1, 1'b1, 64'h104, 4'd4);

        // 4: same-tag refill updates in place and leaves the victim pointer at 4
        refill(27'h302, 16'd1, 64'hDF);
        expect_lookup("t4.upd", 27'h302, 16'd1, 1'b1, 64'hDF, 4'd2);
        refill(27'h400, 16'd1, 64'h44);
        expect_lookup("t4.vict", 27'h400, 16'd1, 1'b1, 64'h44, 4'd4);
        expect_lookup("t4.evict", 27'h204, 16'd1, 1'b0, 64'h0, 4'd0);
        expect_lookup("t4.keep5", 27'h205, 16'd1, 1'b1, 64'h105, 4'd5);

        // 5: flush modes
        flush(2'd0, 27'h0, 16'd0);
        expect_lookup("t5.all0", 27'h205, 16'd1, 1'b0, 64'h0, 4'd0);
        refill(27'h10, 16'd1, 64'h01);
        refill(27'h20, 16'd1, 64'h21);
        refill(27'h30, 16'd2, 64'h03);
        expect_lookup("t5.Bglob", 27'h20, 16'd9, 1'b1, 64'h21, 4'd1);
        flush(2'd1, 27'h0, 16'd1);
        expect_lookup("t5.A", 27'h10, 16'd1, 1'b0, 64'h0, 4'd0);
        expect_lookup("t5.B", 27'h20, 16'd1, 1'b1, 64'h21, 4'd1);
        expect_lookup("t5.C", 27'h30, 16'd2, 1'b1, 64'h03, 4'd2);
        flush(2'd2, 27'h20, 16'd7);
        expect_lookup("t5.Bvpn", 27'h20, 16'd1, 1'b0, 64'h0, 4'd0);
        refill(27'h40, 16'd3, 64'h04);
        flush(2'd3, 27'h40, 16'd4);
        expect_lookup("t5.Dkeep", 27'h40, 16'd3, 1'b1, 64'h04, 4'd0);
        flush(2'd3, 27'h40, 16'd3);
        expect_lookup("t5.Dva", 27'h40, 16'd3, 1'b0, 64'h0, 4'd0);
        expect_lookup("t5.Ckeep", 27'h30, 16'd2, 1'b1, 64'h03, 4'd2);
        flush(2'd0, 27'h0, 16'd0);
        expect_lookup("t5.Call", 27'h30, 16'd2, 1'b0, 64'h0, 4'd0);

        // 6: flush beats refill; flush forces a miss; multihit via global overlap
        refill_valid_i = 1'b1;
        refill_vpn_i   = 27'h50;
        refill_asid_i  = 16'd1;
        refill_pte_i   = 64'h05;
        flush(2'd0, 27'h0, 16'd0);
        expect_lookup("t6.drop", 27'h50, 16'd1, 1'b0, 64'h0, 4'd0);
        refill(27'h60, 16'd1, 64'h06);
        lkp_valid_i = 1'b1;
        lkp_vpn_i   = 27'h60;
        lkp_asid_i  = 16'd1;
        flush(2'd2, 27'h999, 16'd0);
        check("t6.fl.valid", 64'(rsp_valid_o), 64'd1);
        check("t6.fl.hit", 64'(rsp_hit_o), 64'd0);
        check("t6.fl.pte", rsp_pte_o, 64'h0);
        expect_lookup("t6.after", 27'h60, 16'd1, 1'b1, 64'h06, 4'd0);
        refill(27'h70, 16'd1, 64'h07);
        refill(27'h70, 16'd2, 64'h20);
        expect_lookup("t6.mh", 27'h70, 16'd1, 1'b1, 64'h27, 4'd1);
        check("t6.mh.flag", 64'(rsp_multihit_o), 64'd1);
        expect_lookup("t6.single", 27'h70, 16'd3, 1'b1, 64'h20, 4'd2);
        check("t6.single.flag", 64'(rsp_multihit_o), 64'd0);

        // Asynchronous reset drops a pending response and all valid bits
        lookup(27'h60, 16'd1);
        check("rst2.pre", 64'(rsp_valid_o), 64'd1);
        rst_i = 1'b1;
        #1;
        check("rst2.valid", 64'(rsp_valid_o), 64'd0);
        check("rst2.hit", 64'(rsp_hit_o), 64'd0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        expect_lookup("rst2.miss", 27'h60, 16'd1, 1'b0, 64'h0, 4'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
